// File: rtl/smoker_pkg.sv
// Shared constants for the range-hood front end: button bit positions,
// default debounce/long-press timing and the per-button FSM encoding.
package smoker_pkg;

    // Bit positions of the five board buttons in every N_BTN-wide vector
    localparam int BTN_UP     = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_MIDDLE = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_DOWN   = 4;
    localparam int N_BTN_DEF  = 5;

    // 20 ms debounce and 3 s long-press at 100 MHz
    localparam int DEB_CYCLES_DEF  = 2_000_000;
    localparam int LONG_CYCLES_DEF = 300_000_000;

    // Per-button press-tracking state
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,   // debounced level low
        ST_DOWN = 2'd1,   // pressed, hold counter running
        ST_LONG = 2'd2    // long-press reached, held asserted
    } state_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pads and the controller logic.
// There is no handshake: btn_raw is a free-running asynchronous level from the
// pads (master side), every other signal is a registered output of the
// conditioner (slave side), valid on every cycle. Pulses last one cycle.
interface btn_conditioner_if
    import smoker_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    logic [N_BTN-1:0]              btn_raw;
    logic [N_BTN-1:0]              btn_level;
    logic [N_BTN-1:0]              btn_press;
    logic [N_BTN-1:0]              btn_release;
    logic [N_BTN-1:0]              btn_click;
    logic [N_BTN-1:0]              btn_long;
    logic [N_BTN-1:0]              btn_held;
    logic [N_BTN-1:0][STATE_W-1:0] dbg_state;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_click, btn_long, btn_held,
        input  dbg_state
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_click, btn_long, btn_held,
        output dbg_state
    );
endinterface

// File: rtl/btn_debounce_one.sv
// One button: 2-flop synchroniser, debounce counter, press-tracking FSM and
// registered one-cycle event pulses.
module btn_debounce_one
    import smoker_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_raw,
    output logic   o_level,
    output logic   o_press,
    output logic   o_release,
    output logic   o_click,
    output logic   o_long,
    output logic   o_held,
    output state_t o_state
);
    localparam int                DEB_W    = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
    localparam int                HOLD_W   = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    logic              r_sync0, r_sync1;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_level;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press, r_release, r_click, r_long, r_held;

    logic              w_deb_hit, w_rise, w_fall;
    state_t            w_state_next;
    logic [HOLD_W-1:0] w_hold_next;
    logic              w_press_next, w_release_next, w_click_next, w_long_next;
    logic              w_held_next;

    // The level flips on the edge where the counter saturates; the FSM reacts on
    // that same edge so press/release line up with the new level.
    assign w_deb_hit = (r_sync1 != r_level) && (r_deb_cnt == DEB_MAX);
    assign w_rise    = w_deb_hit &&  r_sync1;
    assign w_fall    = w_deb_hit && !r_sync1;

    // Two-flop synchroniser for the asynchronous pad
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
        end else if (r_sync1 == r_level) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_MAX) begin
            r_level   <= r_sync1;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // FSM state and hold counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    // Next state and pulse decode; a fall is checked before the long threshold
    // so a release on the threshold edge is reported as a click, not a long press.
    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_click_next   = 1'b0;
        w_long_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_DOWN;
                    w_press_next = 1'b1;
                    w_hold_next  = '0;
                end
            end
            ST_DOWN: begin
                if (w_fall) begin
                    w_state_next   = ST_IDLE;
                    w_release_next = 1'b1;
                    w_click_next   = 1'b1;
                end else if (r_hold_cnt == HOLD_MAX) begin
                    w_state_next = ST_LONG;
                    w_long_next  = 1'b1;
                end else begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_next   = ST_IDLE;
                    w_release_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_held_next = (w_state_next == ST_LONG);
    end

    // Registered event pulses and held level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_click   <= w_click_next;
            r_long    <= w_long_next;
            r_held    <= w_held_next;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_click   = r_click;
    assign o_long    = r_long;
    assign o_held    = r_held;
    assign o_state   = r_state;

endmodule

// File: rtl/btn_conditioner.sv
// Five-button front end: one independent btn_debounce_one per button bit.
module btn_conditioner
    import smoker_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    btn_conditioner_if.slave  bus
);
    logic [N_BTN-1:0] w_level, w_press, w_release, w_click, w_long, w_held;
    state_t           w_state [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce_one #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_btn (
            .i_clk     (clk),
            .i_rst_n   (rst),
            .i_raw     (bus.btn_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_click   (w_click[g]),
            .o_long    (w_long[g]),
            .o_held    (w_held[g]),
            .o_state   (w_state[g])
        );
        assign bus.dbg_state[g] = w_state[g];
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_click   = w_click;
    assign bus.btn_long    = w_long;
    assign bus.btn_held    = w_held;

endmodule
